// File: rtl/i2c_reg_target.sv
// i2c_reg_target: fabric-side I2C target that emulates a byte-addressed
// register bank at a fixed 7-bit address. The initiator writes a register
// pointer after the address byte. Data bytes that follow are written at the
// pointer, or read back after a repeated START. The pointer auto-increments
// and wraps modulo NUM_REGS. SDA is driven open-drain only, and the block
// never stretches the clock.
//
// Ports:
//   FAB_CLK      fabric clock (>= 20x SCL frequency)
//   FAB_RESET_N  synchronous active-low reset
//   SCL_IN       raw SCL pad input
//   SDA_IN       raw SDA pad input
//   SDA_OE       1 = pull SDA low, 0 = release
//   LD_EN        fabric register load strobe
//   LD_ADDR      load register index
//   LD_DATA      load data
//   WR_STROBE    one-cycle pulse per initiator data byte written
//   WR_ADDR      register index written by the initiator
//   WR_DATA      byte written by the initiator
//   BUSY         high from an addressed START until STOP
`timescale 1ns/1ps
module i2c_reg_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h68,
  parameter int         NUM_REGS    = 16,
  parameter int         PTR_W       = 4
) (
  input  logic             FAB_CLK,
  input  logic             FAB_RESET_N,
  input  logic             SCL_IN,
  input  logic             SDA_IN,
  output logic             SDA_OE,
  input  logic             LD_EN,
  input  logic [PTR_W-1:0] LD_ADDR,
  input  logic [7:0]       LD_DATA,
  output logic             WR_STROBE,
  output logic [PTR_W-1:0] WR_ADDR,
  output logic [7:0]       WR_DATA,
  output logic             BUSY
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  state_t           state;
  logic             scl_p0, scl_p1, scl_p2;
  logic             sda_p0, sda_p1, sda_p2;
  logic             scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0]       shift;
  logic [7:0]       rx_byte;
  logic [2:0]       cnt;
  logic             rw;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic             wr_fire;
  logic [7:0]       regs [NUM_REGS];

  // General call (address 0) is never acknowledged, even if configured.
  function automatic logic addr_hit(input logic [7:0] b);
    return (TARGET_ADDR != 7'h00) && (b[7:1] == TARGET_ADDR);
  endfunction

  // Stage p0/p1: two-flop synchronizer, p2: history flop for edge detect.
  // Reset to 1 (idle bus) so reset itself never looks like a START.
  always_ff @(posedge FAB_CLK) begin
    if (!FAB_RESET_N) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= SCL_IN;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= SDA_IN;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign bus_start = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign bus_stop  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  assign rx_byte = {shift[6:0], sda_p1};
  assign ptr_inc = ptr + PTR_W'(1);
  assign wr_fire = (state == ST_WR_DATA) && scl_rise && (cnt == 3'd7) &&
                   !bus_start && !bus_stop;

  // Register bank: an initiator write is applied after the fabric load,
  // so it wins when both target the same register in the same cycle.
  always_ff @(posedge FAB_CLK) begin
    if (!FAB_RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[PTR_W'(i)] <= 8'h00;
      end
    end else begin
      if (LD_EN) begin
        regs[LD_ADDR] <= LD_DATA;
      end
      if (wr_fire) begin
        regs[ptr] <= rx_byte;
      end
    end
  end

  // Protocol FSM. In the ACK states SDA_OE doubles as the phase flag:
  // the first SCL fall starts the ACK, and the second one ends it.
  always_ff @(posedge FAB_CLK) begin
    if (!FAB_RESET_N) begin
      state     <= ST_IDLE;
      SDA_OE    <= 1'b0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= 8'h00;
      BUSY      <= 1'b0;
      ptr       <= '0;
      cnt       <= 3'd0;
      shift     <= 8'h00;
      rw        <= 1'b0;
    end else begin
      WR_STROBE <= 1'b0;
      if (bus_stop) begin
        state  <= ST_IDLE;
        SDA_OE <= 1'b0;
        BUSY   <= 1'b0;
      end else if (bus_start) begin
        state  <= ST_ADDR;
        cnt    <= 3'd0;
        SDA_OE <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift <= rx_byte;
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (addr_hit(rx_byte)) begin
                  state <= ST_ADDR_ACK;
                  BUSY  <= 1'b1;
                  rw    <= rx_byte[0];
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!SDA_OE) begin
                SDA_OE <= 1'b1;
              end else begin
                cnt <= 3'd0;
                if (rw) begin
                  // First read bit goes out on the same fall that ends the ACK.
                  shift  <= regs[ptr];
                  SDA_OE <= ~regs[ptr][7];
                  state  <= ST_RD_DATA;
                end else begin
                  SDA_OE <= 1'b0;
                  state  <= ST_PTR;
                end
              end
            end
          end
          ST_PTR: begin
            if (scl_rise) begin
              shift <= rx_byte;
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                ptr   <= rx_byte[PTR_W-1:0];
                state <= ST_PTR_ACK;
              end
            end
          end
          ST_PTR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!SDA_OE) begin
                SDA_OE <= 1'b1;
              end else begin
                SDA_OE <= 1'b0;
                cnt    <= 3'd0;
                state  <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise) begin
              shift <= rx_byte;
              cnt   <= cnt + 3'd1;
              if (wr_fire) begin
                WR_STROBE <= 1'b1;
                WR_ADDR   <= ptr;
                WR_DATA   <= rx_byte;
                ptr       <= ptr_inc;
                state     <= ST_WR_ACK;
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) begin
              shift <= {shift[6:0], 1'b0};
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                state <= ST_RD_ACK;
              end
            end else if (scl_fall) begin
              SDA_OE <= ~shift[7];
            end
          end
          ST_RD_ACK: begin
            if (scl_fall) begin
              SDA_OE <= 1'b0;
            end else if (scl_rise) begin
              if (!sda_p1) begin
                ptr   <= ptr_inc;
                shift <= regs[ptr_inc];
                cnt   <= 3'd0;
                state <= ST_RD_DATA;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          default: begin
            SDA_OE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: directed bench for i2c_reg_target. It bit-bangs an I2C
// initiator on a wired-AND SDA bus. Expected write strobes and read bytes are
// queued as the stimulus is issued, then compared when the target produces them.
`timescale 1ns/1ps
module tb_i2c_reg_target;

  localparam int Q = 10;  // FAB_CLK cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic       ld_en;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  int         strobes  = 0;
  logic       mon_en   = 1'b0;
  logic       oe_seen  = 1'b0;
  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_reg_target #(
    .TARGET_ADDR(7'h68),
    .NUM_REGS   (16),
    .PTR_W      (4)
  ) dut (
    .FAB_CLK    (clk),
    .FAB_RESET_N(rst_n),
    .SCL_IN     (scl),
    .SDA_IN     (sda_bus),
    .SDA_OE     (sda_oe),
    .LD_EN      (ld_en),
    .LD_ADDR    (ld_addr),
    .LD_DATA    (ld_data),
    .WR_STROBE  (wr_strobe),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .BUSY       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write-strobe scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
      strobes++;
      checks++;
      assert (exp_wr.size() > 0) else begin
        failures++;
        $error("FAIL wr_unexpected observed=%0h/%0h expected=none", wr_addr, wr_data);
      end
      if (exp_wr.size() > 0) begin
        logic [11:0] e;
        e = exp_wr.pop_front();
        checks--;
        check("wr_strobe", {20'd0, wr_addr, wr_data}, {20'd0, e});
      end
    end
  end

  always @(posedge clk) begin
    if (mon_en && sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wq(Q);
    scl   = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl   = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wq(Q);
    scl   = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; wq(Q);
    scl = 1'b1; wq(2 * Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wq(Q);
    scl = 1'b1; wq(Q);
    b = sda_bus; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic rd_byte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~ack);
  endtask

  // Same as wr_byte but pulses LD_EN in the exact cycle the target commits
  // the byte (third FAB_CLK edge after SCL rises on bit 8).
  task automatic wr_byte_collide(input logic [7:0] v, input logic [3:0] la,
                                 input logic [7:0] ld, output logic ack);
    logic b;
    for (int i = 7; i >= 1; i--) put_bit(v[i]);
    sda_m = v[0]; wq(Q);
    scl = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = la; ld_data = ld;
    @(negedge clk);
    ld_en = 1'b0;
    wq(2 * Q - 2);
    scl = 1'b0; wq(Q);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    wq(1);
    ld_en = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic ack);
    logic [7:0] v;
    logic [7:0] e;
    rd_byte(v, ack);
    e = exp_rd.pop_front();
    check(tag, {24'd0, v}, {24'd0, e});
  endtask

  initial begin
    logic       ack;
    logic       b0, b1, b2;

    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    ld_en = 1'b0; ld_addr = 4'd0; ld_data = 8'h00;
    wq(3);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    wq(4);

    // Write burst
    exp_wr.push_back({4'd3, 8'hA5});
    exp_wr.push_back({4'd4, 8'h5A});
    i2c_start;
    wr_byte(8'hD0, ack); check("wb_ack_addr", {31'd0, ack}, 32'd1);
    check("wb_busy", {31'd0, busy}, 32'd1);
    wr_byte(8'h03, ack); check("wb_ack_ptr", {31'd0, ack}, 32'd1);
    wr_byte(8'hA5, ack); check("wb_ack_d0", {31'd0, ack}, 32'd1);
    wr_byte(8'h5A, ack); check("wb_ack_d1", {31'd0, ack}, 32'd1);
    i2c_stop;
    wq(6);
    check("wb_busy_stop", {31'd0, busy}, 32'd0);
    check("wb_pending", exp_wr.size(), 32'd0);

    // Read with repeated START
    load(4'd5, 8'h3C);
    load(4'd6, 8'hC3);
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'hC3);
    i2c_start;
    wr_byte(8'hD0, ack); check("rd_ack_addr_w", {31'd0, ack}, 32'd1);
    wr_byte(8'h05, ack); check("rd_ack_ptr", {31'd0, ack}, 32'd1);
    i2c_start;
    wr_byte(8'hD1, ack); check("rd_ack_addr_r", {31'd0, ack}, 32'd1);
    read_expect("rd_reg5", 1'b1);
    read_expect("rd_reg6", 1'b0);
    wq(6);
    check("rd_oe_after_nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop;

    // Read back the burst-written registers
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h5A);
    i2c_start;
    wr_byte(8'hD0, ack);
    wr_byte(8'h03, ack);
    i2c_start;
    wr_byte(8'hD1, ack);
    read_expect("rb_reg3", 1'b1);
    read_expect("rb_reg4", 1'b0);
    i2c_stop;

    // Address mismatch
    strobes = 0;
    oe_seen = 1'b0;
    mon_en  = 1'b1;
    i2c_start;
    wr_byte(8'hD2, ack); check("mm_ack_addr", {31'd0, ack}, 32'd0);
    check("mm_busy", {31'd0, busy}, 32'd0);
    wr_byte(8'h00, ack); check("mm_ack_data", {31'd0, ack}, 32'd0);
    i2c_stop;
    wq(6);
    mon_en = 1'b0;
    check("mm_oe_seen", {31'd0, oe_seen}, 32'd0);
    check("mm_strobes", strobes, 32'd0);

    // Pointer wrap, then oversized pointer byte
    exp_wr.push_back({4'd15, 8'h11});
    exp_wr.push_back({4'd0, 8'h22});
    i2c_start;
    wr_byte(8'hD0, ack);
    wr_byte(8'h0F, ack);
    wr_byte(8'h11, ack); check("pw_ack_d0", {31'd0, ack}, 32'd1);
    wr_byte(8'h22, ack); check("pw_ack_d1", {31'd0, ack}, 32'd1);
    i2c_stop;
    exp_wr.push_back({4'd15, 8'h77});
    i2c_start;
    wr_byte(8'hD0, ack);
    wr_byte(8'h1F, ack); check("pw_ack_ptr1f", {31'd0, ack}, 32'd1);
    wr_byte(8'h77, ack);
    i2c_stop;
    wq(4);
    check("pw_pending", exp_wr.size(), 32'd0);
    exp_rd.push_back(8'h77);
    exp_rd.push_back(8'h22);
    i2c_start;
    wr_byte(8'hD0, ack);
    wr_byte(8'h0F, ack);
    i2c_start;
    wr_byte(8'hD1, ack);
    read_expect("pw_reg15", 1'b1);
    read_expect("pw_reg0", 1'b0);
    i2c_stop;

    // Load / initiator write collision on reg 2
    exp_wr.push_back({4'd2, 8'h44});
    i2c_start;
    wr_byte(8'hD0, ack);
    wr_byte(8'h02, ack);
    wr_byte_collide(8'h44, 4'd2, 8'h99, ack); check("col_ack", {31'd0, ack}, 32'd1);
    i2c_stop;
    exp_rd.push_back(8'h44);
    i2c_start;
    wr_byte(8'hD0, ack);
    wr_byte(8'h02, ack);
    i2c_start;
    wr_byte(8'hD1, ack);
    read_expect("col_reg2", 1'b0);
    i2c_stop;

    // Reset in the middle of a read of reg0 (0x22 = 0010_0010)
    i2c_start;
    wr_byte(8'hD0, ack);
    wr_byte(8'h00, ack);
    i2c_start;
    wr_byte(8'hD1, ack);
    get_bit(b0);
    get_bit(b1);
    get_bit(b2);
    check("mr_first_bits", {29'd0, b0, b1, b2}, 32'd1);
    check("mr_oe_bit3", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    wq(1);
    rst_n = 1'b1;
    check("mr_oe_released", {31'd0, sda_oe}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    wq(4);
    i2c_stop;
    exp_rd.push_back(8'h00);
    i2c_start;
    wr_byte(8'hD1, ack); check("mr_ack_addr_r", {31'd0, ack}, 32'd1);
    read_expect("mr_reg0", 1'b0);
    i2c_stop;
    exp_rd.push_back(8'h00);
    i2c_start;
    wr_byte(8'hD0, ack);
    wr_byte(8'h0F, ack);
    i2c_start;
    wr_byte(8'hD1, ack);
    read_expect("mr_reg15", 1'b0);
    i2c_stop;
    wq(6);
    check("end_wr_pending", exp_wr.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
